// File: rtl/enigma_pkg.sv
// Shared constants and state encoding for the Enigma rotor/code-word feeder.
package enigma_pkg;

  localparam int WORD_W      = 6;
  localparam int ROTOR_DEPTH = 1 << WORD_W;
  localparam int ROTOR_WORDS = 2 * ROTOR_DEPTH;
  localparam int IDX_W       = $clog2(ROTOR_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BURST,
    CODE,
    FLUSH
  } state_t;

endpackage

// File: rtl/enigma_feeder_buf.sv
// Rotor table store: one synchronous write port, one asynchronous read port.
module enigma_feeder_buf #(
  parameter int W     = 6,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Unregistered read so the top-level output flop is the only pipeline stage.
  assign rdata = mem[raddr];

endmodule

// File: rtl/enigma_feeder.sv
// Buffers two rotor tables from the host, replays them as one contiguous burst,
// then forwards code words. Define ENIGMA_FEEDER_PERM_CHECK_EN to reject non-permutation rotors.
module enigma_feeder
  import enigma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_mode,
  input  logic              s_last,
  output logic              in_valid,
  output logic              in_valid_2,
  output logic              crypt_mode,
  output logic [WORD_W-1:0] code_in,
  output logic              err,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROTOR_WORDS - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  k;
  logic              mode_q;
  logic              last_q;
  logic              accept;
  logic              buf_we;
  logic              dup_hit;
  logic [WORD_W-1:0] rd_data;

  assign accept = s_valid && s_ready;
  assign buf_we = accept && ((state == IDLE) || (state == LOAD));

  enigma_feeder_buf #(
    .W     (WORD_W),
    .DEPTH (ROTOR_WORDS),
    .AW    (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (s_data),
    .raddr (k),
    .rdata (rd_data)
  );

`ifdef ENIGMA_FEEDER_PERM_CHECK_EN
  logic [ROTOR_DEPTH-1:0] seen_a;
  logic [ROTOR_DEPTH-1:0] seen_b;
  logic                   dup_q;
  logic                   hit;

  // idx[6] selects rotor B for the second half of the table.
  assign hit     = idx[IDX_W-1] ? seen_b[s_data] : seen_a[s_data];
  assign dup_hit = dup_q | hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_a <= '0;
      seen_b <= '0;
      dup_q  <= 1'b0;
    end else if (state == IDLE) begin
      seen_a <= '0;
      seen_b <= '0;
      dup_q  <= 1'b0;
      if (accept) seen_a[s_data] <= 1'b1;
    end else if ((state == LOAD) && accept) begin
      if (idx[IDX_W-1]) seen_b[s_data] <= 1'b1;
      else              seen_a[s_data] <= 1'b1;
      if (hit) dup_q <= 1'b1;
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  // state | meaning
  // IDLE  | waiting for the first table word of a message
  // LOAD  | storing table words 1..127
  // BURST | replaying the 128-word table to the core, in_valid held high
  // CODE  | forwarding code words as in_valid_2 pulses
  // FLUSH | table rejected, dropping words until s_last
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      k          <= '0;
      mode_q     <= 1'b0;
      last_q     <= 1'b0;
      s_ready    <= 1'b0;
      in_valid   <= 1'b0;
      in_valid_2 <= 1'b0;
      crypt_mode <= 1'b0;
      code_in    <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      in_valid   <= 1'b0;
      in_valid_2 <= 1'b0;
      crypt_mode <= 1'b0;
      code_in    <= '0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          busy    <= 1'b0;
          idx     <= '0;
          k       <= '0;
          last_q  <= 1'b0;
          if (accept) begin
            mode_q <= s_mode;
            if (s_last) begin
              err <= 1'b1;
            end else begin
              state <= LOAD;
              idx   <= ONE_IDX;
              busy  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            idx <= idx + ONE_IDX;
            if (idx == LAST_IDX) begin
              if (dup_hit) begin
                if (s_last) begin
                  err   <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
                end else begin
                  state <= FLUSH;
                end
              end else begin
                // First burst word issues on the same edge that stores word 127.
                state      <= BURST;
                s_ready    <= 1'b0;
                last_q     <= s_last;
                in_valid   <= 1'b1;
                code_in    <= rd_data;
                crypt_mode <= mode_q;
                k          <= ONE_IDX;
              end
            end else if (s_last) begin
              err   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
              idx   <= '0;
            end
          end
        end
        BURST: begin
          in_valid <= 1'b1;
          code_in  <= rd_data;
          k        <= k + ONE_IDX;
          if (k == LAST_IDX) begin
            s_ready <= 1'b1;
            if (last_q) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= CODE;
            end
          end
        end
        CODE: begin
          if (accept) begin
            in_valid_2 <= 1'b1;
            code_in    <= s_data;
            if (s_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (accept && s_last) begin
            err   <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
